vga_pixel_sched: RTL and testbench

Frame-level scheduler between the `ppu` pixel stream, a host overlay stream and `vga_driver`. It owns the master raster counters and drives the `ppu` `sync` and `mode` inputs. Each active pixel slot is granted to either the PPU or the host overlay window, and one byte per clock is presented on `vga_driver.wb_data`. Frame alignment is kept by emitting the driver's in-band resync code (`[1:0]==2'b11`).

---
 rtl/vga_pixel_sched_if.sv | 30 +++
 rtl/vga_pixel_sched.sv | 141 ++++++++++++++
 tb/tb_vga_pixel_sched.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_pixel_sched_if.sv
// Signal bundle between vga_pixel_sched and its PPU, host overlay, config and vga_driver neighbours.
// The scheduler connects through the slave modport; the block driving it uses master.
interface vga_pixel_sched_if;
    // stb/ack handshake: a source holds stb with data valid; a word is consumed in a cycle
    // where its slot is granted, stb=1 and ack was low, and ack is then high for one cycle.
    logic [7:0]  ppu_data;
    logic        ppu_stb;
    logic        ppu_ack;
    logic        ppu_sync;
    logic [2:0]  ppu_mode;
    logic [7:0]  host_data;
    logic        host_stb;
    logic        host_ack;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [9:0]  cfg_wdata;
    logic [7:0]  pix_data;
    logic        pix_active;
    logic [15:0] underrun_cnt;

    modport slave (
        input  ppu_data, ppu_stb, host_data, host_stb, cfg_we, cfg_addr, cfg_wdata,
        output ppu_ack, ppu_sync, ppu_mode, host_ack, pix_data, pix_active, underrun_cnt
    );

    modport master (
        output ppu_data, ppu_stb, host_data, host_stb, cfg_we, cfg_addr, cfg_wdata,
        input  ppu_ack, ppu_sync, ppu_mode, host_ack, pix_data, pix_active, underrun_cnt
    );
endinterface

// File: rtl/vga_pixel_sched.sv
// Raster-driven pixel scheduler: grants each active slot to the PPU or the host overlay window.
// Optional starvation counter enabled by VGA_PIXEL_SCHED_UNDERRUN_CNT_EN.
module vga_pixel_sched #(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int LINE      = 799,
    parameter int SCREEN    = 524,
    parameter int MODE_HOLD = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    vga_pixel_sched_if.slave  bus
);
    localparam logic [9:0] H_ACT_C  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT_C  = 10'(V_ACTIVE);
    localparam logic [9:0] LINE_C   = 10'(LINE);
    localparam logic [9:0] SCREEN_C = 10'(SCREEN);
    localparam int         FW       = (MODE_HOLD > 1) ? $clog2(MODE_HOLD) : 1;
    localparam logic [FW-1:0] HOLD_LAST = FW'(MODE_HOLD - 1);
    localparam logic [2:0] MODE_LAST = 3'd5;

    logic [9:0]    sx_q, sx_d, sy_q, sy_d;
    logic [9:0]    sh_x0_q, sh_x0_d, sh_x1_q, sh_x1_d, sh_y0_q, sh_y0_d, sh_y1_q, sh_y1_d;
    logic [9:0]    win_x0_q, win_x0_d, win_x1_q, win_x1_d, win_y0_q, win_y0_d, win_y1_q, win_y1_d;
    logic          sh_auto_q, sh_auto_d;
    logic [2:0]    sh_force_q, sh_force_d;
    logic [2:0]    mode_q, mode_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic [7:0]    last_q, last_d;
    logic [7:0]    pix_q, pix_d;
    logic          act_q, act_d;
    logic          ppu_ack_q, ppu_ack_d, host_ack_q, host_ack_d, sync_q, sync_d;

    logic          frame_end, in_active, in_win, take_ppu, take_host;
    logic [7:0]    pix_sel;

    always_comb begin
        frame_end = (sx_q == LINE_C) && (sy_q == SCREEN_C);
        in_active = (sx_q < H_ACT_C) && (sy_q < V_ACT_C);
        // Inclusive bounds; x0>x1 or y0>y1 naturally yields an empty window.
        in_win    = (sx_q >= win_x0_q) && (sx_q <= win_x1_q) &&
                    (sy_q >= win_y0_q) && (sy_q <= win_y1_q);
        take_host = in_active && in_win && bus.host_stb && !host_ack_q;
        take_ppu  = in_active && !in_win && bus.ppu_stb && !ppu_ack_q;
        pix_sel   = take_host ? bus.host_data : bus.ppu_data;

        last_d     = (take_host || take_ppu) ? (pix_sel & 8'hFC) : last_q;
        act_d      = in_active;
        ppu_ack_d  = take_ppu;
        host_ack_d = take_host;
        sync_d     = frame_end;
        if (frame_end)      pix_d = 8'h03;
        else if (in_active) pix_d = last_d;
        else                pix_d = 8'h00;

        sx_d = (sx_q == LINE_C) ? 10'd0 : sx_q + 10'd1;
        sy_d = sy_q;
        if (sx_q == LINE_C) sy_d = (sy_q == SCREEN_C) ? 10'd0 : sy_q + 10'd1;

        sh_x0_d = sh_x0_q; sh_x1_d = sh_x1_q; sh_y0_d = sh_y0_q; sh_y1_d = sh_y1_q;
        sh_auto_d = sh_auto_q; sh_force_d = sh_force_q;
        if (bus.cfg_we) begin
            case (bus.cfg_addr)
                3'd0: sh_x0_d = bus.cfg_wdata;
                3'd1: sh_x1_d = bus.cfg_wdata;
                3'd2: sh_y0_d = bus.cfg_wdata;
                3'd3: sh_y1_d = bus.cfg_wdata;
                3'd4: begin
                    sh_auto_d  = bus.cfg_wdata[3];
                    sh_force_d = bus.cfg_wdata[2:0];
                end
                default: ;
            endcase
        end

        win_x0_d = win_x0_q; win_x1_d = win_x1_q; win_y0_d = win_y0_q; win_y1_d = win_y1_q;
        mode_d = mode_q;
        fcnt_d = fcnt_q;
        // Live state only moves at the frame boundary, using the shadow values held before it.
        if (frame_end) begin
            win_x0_d = sh_x0_q; win_x1_d = sh_x1_q; win_y0_d = sh_y0_q; win_y1_d = sh_y1_q;
            if (!sh_auto_q) begin
                mode_d = sh_force_q;
                fcnt_d = '0;
            end else if (mode_q > MODE_LAST) begin
                mode_d = 3'd0;
                fcnt_d = '0;
            end else if (fcnt_q == HOLD_LAST) begin
                fcnt_d = '0;
                mode_d = (mode_q == MODE_LAST) ? 3'd0 : mode_q + 3'd1;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sx_q <= '0; sy_q <= '0;
            sh_x0_q <= 10'd1; sh_x1_q <= '0; sh_y0_q <= '0; sh_y1_q <= '0;
            win_x0_q <= 10'd1; win_x1_q <= '0; win_y0_q <= '0; win_y1_q <= '0;
            sh_auto_q <= 1'b1; sh_force_q <= '0;
            mode_q <= '0; fcnt_q <= '0; last_q <= '0; pix_q <= '0; act_q <= 1'b0;
            ppu_ack_q <= 1'b0; host_ack_q <= 1'b0; sync_q <= 1'b0;
        end else begin
            sx_q <= sx_d; sy_q <= sy_d;
            sh_x0_q <= sh_x0_d; sh_x1_q <= sh_x1_d; sh_y0_q <= sh_y0_d; sh_y1_q <= sh_y1_d;
            win_x0_q <= win_x0_d; win_x1_q <= win_x1_d; win_y0_q <= win_y0_d; win_y1_q <= win_y1_d;
            sh_auto_q <= sh_auto_d; sh_force_q <= sh_force_d;
            mode_q <= mode_d; fcnt_q <= fcnt_d; last_q <= last_d; pix_q <= pix_d; act_q <= act_d;
            ppu_ack_q <= ppu_ack_d; host_ack_q <= host_ack_d; sync_q <= sync_d;
        end
    end

    assign bus.pix_data   = pix_q;
    assign bus.pix_active = act_q;
    assign bus.ppu_ack    = ppu_ack_q;
    assign bus.host_ack   = host_ack_q;
    assign bus.ppu_sync   = sync_q;
    assign bus.ppu_mode   = mode_q;

`ifdef VGA_PIXEL_SCHED_UNDERRUN_CNT_EN
    logic [15:0] urun_q, urun_d;
    logic        starved;

    always_comb begin
        starved = in_active && !(take_ppu || take_host);
        urun_d  = urun_q;
        if (starved && (urun_q != 16'hFFFF)) urun_d = urun_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) urun_q <= '0;
        else        urun_q <= urun_d;
    end

    assign bus.underrun_cnt = urun_q;
`else
    assign bus.underrun_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_vga_pixel_sched.sv
// Bench for vga_pixel_sched on a shrunken raster (12x7 cycles per frame) with a cycle scoreboard.
module tb_vga_pixel_sched;
  localparam int H_ACTIVE  = 8;
  localparam int V_ACTIVE  = 4;
  localparam int LINE      = 11;
  localparam int SCREEN    = 6;
  localparam int MODE_HOLD = 2;
  localparam int FRAME     = (LINE + 1) * (SCREEN + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  logic [30:0] exp_q[$];

  vga_pixel_sched_if bus();

  vga_pixel_sched #(
    .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .LINE(LINE), .SCREEN(SCREEN), .MODE_HOLD(MODE_HOLD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model: predicts registered outputs for the slot seen at each rising edge
  int m_sx, m_sy, m_fcnt, m_cnt;
  int sh_x0, sh_x1, sh_y0, sh_y1, lv_x0, lv_x1, lv_y0, lv_y1;
  logic sh_auto;
  logic [2:0] sh_force, m_mode;
  logic m_pack, m_hack;
  logic [7:0] m_last;

  always @(posedge clk) begin : model
    logic bnd, act, win, pok, hok;
    logic [7:0] pix;
    if (!rst_n) begin
      m_sx = 0; m_sy = 0; m_fcnt = 0; m_cnt = 0;
      sh_x0 = 1; sh_x1 = 0; sh_y0 = 0; sh_y1 = 0;
      lv_x0 = 1; lv_x1 = 0; lv_y0 = 0; lv_y1 = 0;
      sh_auto = 1'b1; sh_force = 3'd0; m_mode = 3'd0;
      m_pack = 1'b0; m_hack = 1'b0; m_last = 8'h00;
      exp_q.delete();
    end else begin
      bnd = (m_sx == LINE) && (m_sy == SCREEN);
      act = (m_sx < H_ACTIVE) && (m_sy < V_ACTIVE);
      win = (m_sx >= lv_x0) && (m_sx <= lv_x1) && (m_sy >= lv_y0) && (m_sy <= lv_y1);
      pok = act && !win && bus.ppu_stb && !m_pack;
      hok = act && win && bus.host_stb && !m_hack;
      if (pok) m_last = bus.ppu_data & 8'hFC;
      if (hok) m_last = bus.host_data & 8'hFC;
      pix = bnd ? 8'h03 : (act ? m_last : 8'h00);
`ifdef VGA_PIXEL_SCHED_UNDERRUN_CNT_EN
      if (act && !pok && !hok && m_cnt < 65535) m_cnt = m_cnt + 1;
`endif
      if (bnd) begin
        lv_x0 = sh_x0; lv_x1 = sh_x1; lv_y0 = sh_y0; lv_y1 = sh_y1;
        if (!sh_auto) begin
          m_mode = sh_force; m_fcnt = 0;
        end else if (m_mode > 3'd5) begin
          m_mode = 3'd0; m_fcnt = 0;
        end else if (m_fcnt == MODE_HOLD - 1) begin
          m_fcnt = 0;
          m_mode = (m_mode == 3'd5) ? 3'd0 : 3'(m_mode + 3'd1);
        end else begin
          m_fcnt = m_fcnt + 1;
        end
      end
      if (bus.cfg_we) begin
        case (bus.cfg_addr)
          3'd0: sh_x0 = int'(bus.cfg_wdata);
          3'd1: sh_x1 = int'(bus.cfg_wdata);
          3'd2: sh_y0 = int'(bus.cfg_wdata);
          3'd3: sh_y1 = int'(bus.cfg_wdata);
          3'd4: begin sh_auto = bus.cfg_wdata[3]; sh_force = bus.cfg_wdata[2:0]; end
          default: ;
        endcase
      end
      m_pack = pok;
      m_hack = hok;
      if (m_sx == LINE) begin
        m_sx = 0;
        m_sy = (m_sy == SCREEN) ? 0 : m_sy + 1;
      end else begin
        m_sx = m_sx + 1;
      end
      exp_q.push_back({pix, act, pok, hok, bnd, m_mode, 16'(m_cnt)});
    end
  end

  // scoreboard: compare every registered output word on the falling edge
  always @(negedge clk) begin : scoreboard
    logic [30:0] exp_w, got_w;
    if (exp_q.size() > 0) begin
      exp_w = exp_q.pop_front();
      got_w = {bus.pix_data, bus.pix_active, bus.ppu_ack, bus.host_ack, bus.ppu_sync,
               bus.ppu_mode, bus.underrun_cnt};
      total++;
      if (got_w !== exp_w) begin
        bad++;
        $display("FAIL scoreboard t=%0t got pix=%h act=%b pack=%b hack=%b sync=%b mode=%0d cnt=%h exp pix=%h act=%b pack=%b hack=%b sync=%b mode=%0d cnt=%h",
                 $time, got_w[30:23], got_w[22], got_w[21], got_w[20], got_w[19], got_w[18:16], got_w[15:0],
                 exp_w[30:23], exp_w[22], exp_w[21], exp_w[20], exp_w[19], exp_w[18:16], exp_w[15:0]);
      end
    end
  end

  // driver tasks
  task automatic cfg_write(input logic [2:0] a, input logic [9:0] d);
    @(negedge clk);
    bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_wdata = d;
    @(negedge clk);
    bus.cfg_we = 1'b0;
  endtask

  task automatic wait_sync(input string tag);
    bit seen = 0;
    for (int i = 0; i < FRAME + 8 && !seen; i++) begin
      @(negedge clk);
      if (bus.ppu_sync === 1'b1) seen = 1;
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL %s_sync_timeout got no ppu_sync required one within %0d cycles", tag, FRAME + 8);
    end
  endtask

  task automatic test_reset;
    logic [30:0] got;
    int n;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    got = {bus.pix_data, bus.pix_active, bus.ppu_ack, bus.host_ack, bus.ppu_sync, bus.ppu_mode, bus.underrun_cnt};
    total++;
    if (got !== 31'd0) begin bad++; $display("FAIL reset_outputs got %h required 0", got); end
    #1 rst_n = 1'b1;
    n = 0;
    for (int i = 1; i <= FRAME + 4 && n == 0; i++) begin
      @(negedge clk);
      if (bus.ppu_sync === 1'b1) n = i;
    end
    total++;
    if (n != FRAME) begin bad++; $display("FAIL first_sync got edge %0d required %0d", n, FRAME); end
    total++;
    if (bus.pix_data !== 8'h03) begin bad++; $display("FAIL resync_code got %h required 03", bus.pix_data); end
    @(negedge clk);
    total++;
    if (bus.ppu_sync !== 1'b0 || bus.pix_active !== 1'b1) begin
      bad++; $display("FAIL after_sync got sync=%b act=%b required sync=0 act=1", bus.ppu_sync, bus.pix_active);
    end
  endtask

  task automatic test_ppu_stream;
    int pack_n = 0, hack_n = 0, act_n = 0, fc_n = 0;
    bus.ppu_stb = 1'b1; bus.ppu_data = 8'hFF;
    wait_sync("ppu");
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      pack_n += int'(bus.ppu_ack);
      hack_n += int'(bus.host_ack);
      act_n  += int'(bus.pix_active);
      if (bus.pix_active && bus.pix_data === 8'hFC) fc_n++;
    end
    total++;
    if (pack_n != H_ACTIVE * V_ACTIVE / 2) begin bad++; $display("FAIL ppu_ack_count got %0d required %0d", pack_n, H_ACTIVE * V_ACTIVE / 2); end
    total++;
    if (hack_n != 0) begin bad++; $display("FAIL host_ack_empty_win got %0d required 0", hack_n); end
    total++;
    if (act_n != H_ACTIVE * V_ACTIVE || fc_n != H_ACTIVE * V_ACTIVE) begin
      bad++; $display("FAIL ppu_pixels got act=%0d fc=%0d required %0d", act_n, fc_n, H_ACTIVE * V_ACTIVE);
    end
  endtask

  task automatic test_window;
    int pack_n = 0, hack_n = 0, c0_n = 0;
    cfg_write(3'd0, 10'd2);
    cfg_write(3'd1, 10'd5);
    cfg_write(3'd2, 10'd1);
    cfg_write(3'd3, 10'd1);
    bus.host_stb = 1'b1; bus.host_data = 8'hC3;
    wait_sync("window");
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      pack_n += int'(bus.ppu_ack);
      hack_n += int'(bus.host_ack);
      if (bus.pix_active && bus.pix_data === 8'hC0) c0_n++;
    end
    // 4-wide window with stb held high: take, stall, take, stall
    total++;
    if (hack_n != 2) begin bad++; $display("FAIL host_ack_count got %0d required 2", hack_n); end
    total++;
    if (pack_n != 14) begin bad++; $display("FAIL ppu_ack_with_win got %0d required 14", pack_n); end
    total++;
    if (c0_n != 4) begin bad++; $display("FAIL overlay_pixels got %0d required 4", c0_n); end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      bus.ppu_stb   = 1'($urandom_range(0, 1));
      bus.host_stb  = 1'($urandom_range(0, 1));
      bus.ppu_data  = 8'($urandom_range(0, 255));
      bus.host_data = 8'($urandom_range(0, 255));
      bus.cfg_we    = ($urandom_range(0, 9) == 0);
      bus.cfg_addr  = 3'($urandom_range(0, 7));
      bus.cfg_wdata = 10'($urandom_range(0, 12));
      total++;
      if (bus.ppu_ack === 1'b1 && bus.host_ack === 1'b1) begin
        bad++; $display("FAIL ack_exclusive got both acks high required at most one");
      end
    end
    bus.cfg_we = 1'b0;
  endtask

`ifdef VGA_PIXEL_SCHED_UNDERRUN_CNT_EN
  task automatic test_saturation;
    bus.ppu_stb = 1'b0; bus.host_stb = 1'b0;
    @(negedge clk);
    #2 force dut.urun_q = 16'hFFFE;
    #1 release dut.urun_q;
    m_cnt = 65534;
    repeat (2 * FRAME) @(negedge clk);
    total++;
    if (bus.underrun_cnt !== 16'hFFFF) begin bad++; $display("FAIL underrun_sat got %h required ffff", bus.underrun_cnt); end
  endtask
`endif

  task automatic test_auto_mode;
    logic [2:0] seq [14] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4, 3'd5, 3'd5, 3'd0, 3'd0};
    bus.ppu_stb = 1'b0; bus.host_stb = 1'b0; bus.cfg_we = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    for (int f = 0; f < 14; f++) begin
      repeat (FRAME / 2) @(negedge clk);
      total++;
      if (bus.ppu_mode !== seq[f]) begin bad++; $display("FAIL auto_mode frame %0d got %0d required %0d", f, bus.ppu_mode, seq[f]); end
      repeat (FRAME - FRAME / 2) @(negedge clk);
    end
  endtask

  task automatic test_forced_mode;
    bit done = 0;
    repeat (20) @(negedge clk);
    cfg_write(3'd4, 10'h007);
    for (int i = 0; i < FRAME + 8 && !done; i++) begin
      @(negedge clk);
      total++;
      if (bus.ppu_sync === 1'b1) begin
        done = 1;
        if (bus.ppu_mode !== 3'd7) begin bad++; $display("FAIL forced_apply got %0d required 7", bus.ppu_mode); end
      end else if (bus.ppu_mode !== 3'd1) begin
        bad++; $display("FAIL forced_early got %0d required 1", bus.ppu_mode);
      end
    end
    total++;
    if (!done) begin bad++; $display("FAIL forced_sync_timeout got no boundary required one"); end
    for (int i = 0; i < FRAME + 10; i++) begin
      @(negedge clk);
      total++;
      if (bus.ppu_mode !== 3'd7) begin bad++; $display("FAIL forced_hold got %0d required 7", bus.ppu_mode); end
    end
  endtask

  task automatic test_reset_mid;
    logic [30:0] got;
    bus.ppu_stb = 1'b1; bus.host_stb = 1'b1;
    bus.ppu_data = 8'h5A; bus.host_data = 8'hA5;
    repeat (30) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 got = {bus.pix_data, bus.pix_active, bus.ppu_ack, bus.host_ack, bus.ppu_sync, bus.ppu_mode, bus.underrun_cnt};
    total++;
    if (got !== 31'd0) begin bad++; $display("FAIL reset_mid got %h required 0", got); end
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (FRAME + 4) @(negedge clk);
  endtask

  initial begin
    bus.ppu_data = 8'h00; bus.ppu_stb = 1'b0;
    bus.host_data = 8'h00; bus.host_stb = 1'b0;
    bus.cfg_we = 1'b0; bus.cfg_addr = 3'd0; bus.cfg_wdata = 10'd0;
    test_reset();
    test_ppu_stream();
    test_window();
    test_back_to_back();
`ifdef VGA_PIXEL_SCHED_UNDERRUN_CNT_EN
    test_saturation();
`endif
    test_auto_mode();
    test_forced_mode();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
